// File: rtl/alu_mdu_dec_pkg.sv
// Shared constants for the EX-stage ALU decoder and the multiply/divide unit.
// Covers ALUOp classes, funct codes, ALUControl encodings and sequencer states.
package alu_mdu_dec_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // Base 4-bit encodings; wider ALUControl words zero-extend these
    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_AND  = 4'b0010;
    localparam logic [3:0] CTRL_OR   = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_NOR  = 4'b0101;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLL  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1001;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;
    localparam logic [3:0] CTRL_SLTU = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;

endpackage

// File: rtl/alu_mdu_dec_mdu_iter.sv
// Iterative multiply/divide sequencer: one bit per cycle on operand magnitudes,
// with sign and divide-by-zero correction presented combinationally in FIX.
module mdu_iter
    import alu_mdu_dec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb, orig_a;
    logic               div_op, neg_q, neg_r, div_zero;

    logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign q_bit    = (rem_sh >= {1'b0, opb});

    assign quot     = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_q ? -acc : acc;

    assign busy = (state != IDLE);
    assign done = (state == FIX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = is_div ? DIV : MUL;
            MUL, DIV: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            orig_a   <= '0;
            div_op   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc      <= {{WIDTH{1'b0}}, a_mag};
                    opb      <= b_mag;
                    orig_a   <= a;
                    cnt      <= CNT_W'(WIDTH);
                    div_op   <= is_div;
                    neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r    <= is_signed && a[WIDTH-1];
                    div_zero <= is_div && (b == '0);
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                end
                DIV: begin
                    acc <= {(q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hi = '0;
        lo = '0;
        if (div_op && div_zero) begin
            lo = '1;
            hi = orig_a;
        end else if (div_op) begin
            lo = neg_q ? -quot : quot;
            hi = neg_r ? -rem : rem;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu_dec.sv
// EX-stage ALU decoder with HI/LO registers and a stalling multiply/divide unit.
// Decode is purely combinational; HI/LO are written by mthi/mtlo or on MDU completion.
module alu_mdu_dec
    import alu_mdu_dec_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [5:0]        funct,
    input  logic [1:0]        ALUOp,
    input  logic [WIDTH-1:0]  srca,
    input  logic [WIDTH-1:0]  srcb,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              illegal,
    output logic              use_hilo,
    output logic [WIDTH-1:0]  hilo_out,
    output logic              stall,
    output logic              busy
);

    logic [3:0]       ctrl;
    logic             funct_op, is_mf, is_mt, is_mdu, hilo_op, start;
    logic             mdu_busy, mdu_done;
    logic [WIDTH-1:0] mdu_hi, mdu_lo, hi_q, lo_q;

    always_comb begin
        ctrl    = CTRL_ADD;
        illegal = 1'b0;
        case (ALUOp)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_OR:  ctrl = CTRL_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD, F_ADDU: ctrl = CTRL_ADD;
                    F_SUB, F_SUBU: ctrl = CTRL_SUB;
                    F_AND:         ctrl = CTRL_AND;
                    F_OR:          ctrl = CTRL_OR;
                    F_XOR:         ctrl = CTRL_XOR;
                    F_NOR:         ctrl = CTRL_NOR;
                    F_SLT:         ctrl = CTRL_SLT;
                    F_SLTU:        ctrl = CTRL_SLTU;
                    F_SLL:         ctrl = CTRL_SLL;
                    F_SRL:         ctrl = CTRL_SRL;
                    F_SRA:         ctrl = CTRL_SRA;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = CTRL_ADD;
                    default:       illegal = 1'b1;
                endcase
            end
            default: ctrl = CTRL_ADD;
        endcase
    end

    assign ALUControl = CTRL_W'(ctrl);

    assign funct_op = valid && (ALUOp == ALUOP_FUNCT);
    assign is_mf    = (funct == F_MFHI) || (funct == F_MFLO);
    assign is_mt    = (funct == F_MTHI) || (funct == F_MTLO);
    assign is_mdu   = funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    assign use_hilo = funct_op && is_mf;
    assign hilo_op  = funct_op && (is_mdu || is_mf || is_mt);
    // Only HI/LO users wait on the sequencer; a busy MDU never accepts a restart
    assign stall    = hilo_op && mdu_busy;
    assign start    = funct_op && is_mdu && !mdu_busy;
    assign busy     = mdu_busy;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_div    ((funct == F_DIV) || (funct == F_DIVU)),
        .is_signed ((funct == F_MULT) || (funct == F_DIV)),
        .a         (srca),
        .b         (srcb),
        .busy      (mdu_busy),
        .done      (mdu_done),
        .hi        (mdu_hi),
        .lo        (mdu_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mdu_done) begin
            hi_q <= mdu_hi;
            lo_q <= mdu_lo;
        end else if (funct_op && !mdu_busy) begin
            if (funct == F_MTHI) hi_q <= srca;
            if (funct == F_MTLO) lo_q <= srca;
        end
    end

    assign hilo_out = (funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_mdu_dec.sv
// Self-checking bench for alu_mdu_dec: decode sweep, directed and random MDU ops
// against an arithmetic reference model, stall/busy timing, mthi/mtlo, mid-op reset.
module tb_alu_mdu_dec;

    localparam int W = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid = 1'b0;
    logic [5:0]   funct = '0;
    logic [1:0]   ALUOp = '0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic [3:0]   ALUControl;
    logic         illegal, use_hilo, stall, busy;
    logic [W-1:0] hilo_out;

    int total = 0;
    int bad = 0;

    logic [5:0] dec_f [21] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                              6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                              6'b000000, 6'b000010, 6'b000011, 6'b010000, 6'b010001,
                              6'b010010, 6'b010011, 6'b011000, 6'b011001, 6'b011010,
                              6'b011011};
    logic [3:0] dec_c [21] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010,
                              4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b1011,
                              4'b1000, 4'b1001, 4'b1010, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000};

    always #5 clk = ~clk;

    alu_mdu_dec #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .funct      (funct),
        .ALUOp      (ALUOp),
        .srca       (srca),
        .srcb       (srcb),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .use_hilo   (use_hilo),
        .hilo_out   (hilo_out),
        .stall      (stall),
        .busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        valid = v;
        ALUOp = op;
        funct = f;
        srca  = a;
        srcb  = b;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference results from plain signed/unsigned 64-bit arithmetic
    function automatic void refMdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = '0;
        lo = '0;
        if (f == FN_MULT) begin
            sq = sa * sb;
            hi = sq[63:32];
            lo = sq[31:0];
        end else if (f == FN_MULTU) begin
            up = ua * ub;
            hi = up[63:32];
            lo = up[31:0];
        end else if (b == '0) begin
            hi = a;
            lo = '1;
        end else if (f == FN_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            hi = sr[31:0];
            lo = sq[31:0];
        end else begin
            up = ua / ub;
            hi = W'(ua % ub);
            lo = up[31:0];
        end
    endfunction

    // Issue an MDU op, follow it with mflo until unstalled, then read mfhi
    task automatic runMdu(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ehi, elo;
        int n;
        refMdu(f, a, b, ehi, elo);
        applyStimulus(1'b1, 2'b10, f, a, b);
        @(negedge clk);
        checkOutput({tag, " issue stall"}, W'(stall), '0);
        cycle();
        applyStimulus(1'b1, 2'b10, FN_MFLO, $urandom, $urandom);
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            cycle();
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " stall cycles"}, W'(n), W'(W + 1));
        checkOutput({tag, " busy after"}, W'(busy), '0);
        checkOutput({tag, " lo"}, hilo_out, elo);
        cycle();
        funct = FN_MFHI;
        @(negedge clk);
        checkOutput({tag, " hi"}, hilo_out, ehi);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ehi1, elo1, ra, rb;
        logic [5:0]   rf;
        int n;

        applyStimulus(1'b1, 2'b10, FN_MFLO, '0, '0);
        #12;
        checkOutput("reset busy", W'(busy), '0);
        checkOutput("reset stall", W'(stall), '0);
        checkOutput("reset hilo_out", hilo_out, '0);
        checkOutput("reset use_hilo follows", W'(use_hilo), W'(1));
        reset = 1'b1;
        cycle();

        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b0, 2'b10, dec_f[i], '0, '0);
            @(negedge clk);
            checkOutput($sformatf("dec ctrl f=%b", dec_f[i]), W'(ALUControl), W'(dec_c[i]));
            checkOutput($sformatf("dec illegal f=%b", dec_f[i]), W'(illegal), '0);
            cycle();
        end
        applyStimulus(1'b0, 2'b10, 6'b111111, '0, '0);
        @(negedge clk);
        checkOutput("dec ctrl f=111111", W'(ALUControl), '0);
        checkOutput("dec illegal f=111111", W'(illegal), W'(1));
        applyStimulus(1'b0, 2'b00, 6'b111111, '0, '0);
        #1;
        checkOutput("aluop00 ctrl", W'(ALUControl), W'(4'b0000));
        checkOutput("aluop00 illegal", W'(illegal), '0);
        ALUOp = 2'b01;
        #1;
        checkOutput("aluop01 ctrl", W'(ALUControl), W'(4'b0001));
        ALUOp = 2'b11;
        #1;
        checkOutput("aluop11 ctrl", W'(ALUControl), W'(4'b0011));
        applyStimulus(1'b0, 2'b10, FN_MFLO, '0, '0);
        #1;
        checkOutput("use_hilo invalid", W'(use_hilo), '0);
        cycle();

        runMdu("mult -3*5", FN_MULT, -32'sd3, 32'd5);
        runMdu("divu 100/7", FN_DIVU, 32'd100, 32'd7);
        runMdu("div -7/2", FN_DIV, -32'sd7, 32'd2);
        runMdu("div by zero", FN_DIV, 32'h0000_1234, 32'd0);
        runMdu("div overflow", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runMdu("divu by zero", FN_DIVU, 32'hDEAD_BEEF, 32'd0);

        for (int i = 0; i < 8; i++) begin
            rf = {4'b0110, 2'($urandom_range(0, 3))};
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb = $urandom_range(1, 100);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            runMdu($sformatf("rand%0d f=%b", i, rf), rf, ra, rb);
        end

        refMdu(FN_MULT, 32'd1234, -32'sd77, ehi1, elo1);
        applyStimulus(1'b1, 2'b10, FN_MULT, 32'd1234, -32'sd77);
        @(negedge clk);
        cycle();
        applyStimulus(1'b1, 2'b10, FN_ADD, 32'd1, 32'd2);
        @(negedge clk);
        checkOutput("add during mult stall", W'(stall), '0);
        checkOutput("add during mult busy", W'(busy), W'(1));
        cycle();
        applyStimulus(1'b1, 2'b10, FN_MULTU, 32'hFFFF_0000, 32'h0001_0001);
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            cycle();
            @(negedge clk);
            n++;
        end
        checkOutput("second mult stall cycles", W'(n), W'(W));
        applyStimulus(1'b1, 2'b10, FN_MFLO, '0, '0);
        #1;
        checkOutput("first mult lo intact", hilo_out, elo1);
        checkOutput("no restart busy", W'(busy), '0);
        cycle();
        funct = FN_MFHI;
        @(negedge clk);
        checkOutput("first mult hi intact", hilo_out, ehi1);
        cycle();

        applyStimulus(1'b1, 2'b10, FN_MTLO, 32'h0000_00A5, '0);
        @(negedge clk);
        cycle();
        applyStimulus(1'b1, 2'b10, FN_MFLO, '0, '0);
        @(negedge clk);
        checkOutput("mtlo then mflo", hilo_out, 32'h0000_00A5);
        cycle();
        applyStimulus(1'b1, 2'b10, FN_MTHI, 32'h0000_005A, '0);
        @(negedge clk);
        cycle();
        applyStimulus(1'b1, 2'b10, FN_MFHI, '0, '0);
        @(negedge clk);
        checkOutput("mthi then mfhi", hilo_out, 32'h0000_005A);
        cycle();

        applyStimulus(1'b1, 2'b10, FN_DIV, 32'd1000, 32'd3);
        @(negedge clk);
        cycle();
        applyStimulus(1'b1, 2'b10, FN_MFLO, '0, '0);
        repeat (22) cycle();
        @(negedge clk);
        checkOutput("mid-div stall before reset", W'(stall), W'(1));
        reset = 1'b0;
        #1;
        checkOutput("mid-div reset busy", W'(busy), '0);
        checkOutput("mid-div reset stall", W'(stall), '0);
        checkOutput("mid-div reset lo", hilo_out, '0);
        funct = FN_MFHI;
        #1;
        checkOutput("mid-div reset hi", hilo_out, '0);
        #1;
        reset = 1'b1;
        cycle();
        runMdu("mult after reset", FN_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

        applyStimulus(1'b0, 2'b00, '0, '0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
